// File: rtl/bcd_7seg_scan_driver.sv
// bcd_7seg_scan_driver
// Multiplexed N-digit BCD to 7-segment scan driver. A packed BCD word is
// latched into a shadow register on load, and the digits are scanned one
// slot at a time onto a shared segment bus. Each slot starts with a short
// all-off interval to suppress ghosting between neighbouring digits.
// Optional build macro: SEVSEG_LZB_EN enables leading-zero blanking.
module bcd_7seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int COMMON_CATHODE = 0,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  // Inactive levels: common cathode drives segments high / digits low when lit.
  localparam logic [6:0]        SEG_OFF  = (COMMON_CATHODE != 0) ? 7'h00 : 7'h7F;
  localparam logic [DIGITS-1:0] DIG_OFF  = (COMMON_CATHODE != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Standard BCD glyphs in active-high {a..g} form; illegal codes show 'E'.
  function automatic logic [6:0] bcd_decode(input logic [3:0] code);
    case (code)
      4'd0:    bcd_decode = 7'b1111110;
      4'd1:    bcd_decode = 7'b0110000;
      4'd2:    bcd_decode = 7'b1101101;
      4'd3:    bcd_decode = 7'b1111001;
      4'd4:    bcd_decode = 7'b0110011;
      4'd5:    bcd_decode = 7'b1011011;
      4'd6:    bcd_decode = 7'b1011111;
      4'd7:    bcd_decode = 7'b1110000;
      4'd8:    bcd_decode = 7'b1111111;
      4'd9:    bcd_decode = 7'b1111011;
      default: bcd_decode = 7'b1001111;
    endcase
  endfunction

  logic [4*DIGITS-1:0] shadow_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic                frame_r;
  logic [6:0]          seg_r;
  logic [DIGITS-1:0]   dig_sel_r;

  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [IDX_W-1:0]    idx_nxt_s;
  logic                wrap_s;
  logic                blank_s;
  logic [3:0]          digit_s;
  logic [DIGITS-1:0]   onehot_s;
  logic                lz_sel_s;
  logic [6:0]          seg_nxt_s;
  logic [DIGITS-1:0]   dig_nxt_s;

  // Prescaler and scan index: advance the digit at the last cycle of each slot.
  always_comb begin
    cnt_nxt_s = cnt_r;
    idx_nxt_s = idx_r;
    wrap_s    = 1'b0;
    if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_nxt_s = {IDX_W{1'b0}};
        wrap_s    = 1'b1;
      end else begin
        idx_nxt_s = idx_r + IDX_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // With no blank interval the comparison would be constant, so it is not built.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank_s = 1'b0;
    end else begin : g_blank
      assign blank_s = (cnt_r < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  // Select the shadow digit for the current slot and build its one-hot enable.
  always_comb begin
    digit_s  = 4'h0;
    onehot_s = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_r == IDX_W'(k)) begin
        digit_s     = shadow_r[4*k +: 4];
        onehot_s[k] = 1'b1;
      end else begin
        onehot_s[k] = 1'b0;
      end
    end
  end

`ifdef SEVSEG_LZB_EN
  logic [DIGITS-1:0] lz_s;

  // A digit is a leading zero when it and every more significant digit is 0; digit 0 always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_s       = {DIGITS{1'b0}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (shadow_r[4*k +: 4] == 4'h0);
      lz_s[k]    = zero_above & (k != 0);
    end
  end

  assign lz_sel_s = |(lz_s & onehot_s);
`else
  assign lz_sel_s = 1'b0;
`endif

  // Next output values: all off during the blank interval, else the selected digit.
  always_comb begin
    seg_nxt_s = SEG_OFF;
    dig_nxt_s = DIG_OFF;
    if (blank_s) begin
      seg_nxt_s = SEG_OFF;
      dig_nxt_s = DIG_OFF;
    end else begin
      dig_nxt_s = (COMMON_CATHODE != 0) ? ~onehot_s : onehot_s;
      if (lz_sel_s) begin
        seg_nxt_s = SEG_OFF;
      end else begin
        seg_nxt_s = (COMMON_CATHODE != 0) ? bcd_decode(digit_s) : ~bcd_decode(digit_s);
      end
    end
  end

  // State and registered outputs; reset forces everything off and clears the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r  <= {(4*DIGITS){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      frame_r   <= 1'b0;
      seg_r     <= SEG_OFF;
      dig_sel_r <= DIG_OFF;
    end else begin
      cnt_r     <= cnt_nxt_s;
      idx_r     <= idx_nxt_s;
      frame_r   <= wrap_s;
      seg_r     <= seg_nxt_s;
      dig_sel_r <= dig_nxt_s;
      if (load) begin
        shadow_r <= bcd_in;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  assign seg     = seg_r;
  assign dig_sel = dig_sel_r;
  assign frame   = frame_r;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Testbench for bcd_7seg_scan_driver. Instance A: 4 digits, common anode,
// 4-cycle slots with 1 blank cycle. Instance B: 1 digit, common cathode,
// 2-cycle slots, no blanking. Stimulus pushes expected outputs tagged with
// the clock edge they belong to; a monitor pops and compares them.
module tb_bcd_7seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, load_a;
  logic [15:0] bcd_a;
  logic [6:0]  seg_a;
  logic [3:0]  dig_a;
  logic        frame_a;

  logic        rst_b, load_b;
  logic [3:0]  bcd_b;
  logic [6:0]  seg_b;
  logic [0:0]  dig_b;
  logic        frame_b;

  bcd_7seg_scan_driver #(.DIGITS(4), .COMMON_CATHODE(0), .SCAN_DIV(4), .BLANK_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst_a), .load(load_a), .bcd_in(bcd_a),
    .seg(seg_a), .dig_sel(dig_a), .frame(frame_a)
  );

  bcd_7seg_scan_driver #(.DIGITS(1), .COMMON_CATHODE(1), .SCAN_DIV(2), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .load(load_b), .bcd_in(bcd_b),
    .seg(seg_b), .dig_sel(dig_b), .frame(frame_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          tst;
    logic [11:0] val;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   n_checks = 0;
  int   n_fails = 0;
  bit   finishing = 1'b0;

  // Hand-written glyph table, active-high {a..g}
  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'd0: return 7'h7E;
      4'd1: return 7'h30;
      4'd2: return 7'h6D;
      4'd3: return 7'h79;
      4'd4: return 7'h33;
      4'd5: return 7'h5B;
      4'd6: return 7'h5F;
      4'd7: return 7'h70;
      4'd8: return 7'h7F;
      4'd9: return 7'h7B;
      default: return 7'h4F;
    endcase
  endfunction

  // Expected {seg, dig_sel, frame} of instance A after the m-th edge since reset release
  function automatic logic [11:0] exp_a(input int m, input logic [15:0] sh);
    int          cnt;
    int          idx;
    logic        fr;
    logic [15:0] upper;
    logic [6:0]  s;
    logic [3:0]  one;
    logic [3:0]  d;
    cnt = (m - 1) % 4;
    idx = ((m - 1) / 4) % 4;
    fr  = (m % 16 == 0);
    if (cnt == 0) return {7'h7F, 4'b0000, fr};
    upper = sh >> (4 * idx);
    s = ~dec(upper[3:0]);
`ifdef SEVSEG_LZB_EN
    if (idx != 0 && upper == 16'h0000) s = 7'h7F;
`endif
    one = 4'b0001;
    d = one << idx;
    return {s, d, fr};
  endfunction

  // Expected output of instance B: digit always enabled (active low), frame every 2nd edge
  function automatic logic [11:0] exp_b(input int m, input int code);
    logic [3:0] c;
    c = code[3:0];
    return {dec(c), 3'b000, 1'b0, (m % 2 == 0)};
  endfunction

  task automatic push_a(input int c, input int t, input logic [11:0] v);
    ent_t e;
    e.cyc = c; e.tst = t; e.val = v;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input int t, input logic [11:0] v);
    ent_t e;
    e.cyc = c; e.tst = t; e.val = v;
    qb.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic run_a();
    int base;
    rst_a = 1'b1; load_a = 1'b0; bcd_a = 16'h0000;
    for (int c = 1; c <= 3; c++) push_a(c, 1, {7'h7F, 4'b0000, 1'b0});
    wait_cyc(3);
    rst_a = 1'b0;
    base = 3;
    // Scan of 1234 over two frames
    bcd_a = 16'h1234; load_a = 1'b1;
    for (int m = 1; m <= 32; m++) push_a(base + m, 3, exp_a(m, (m == 1) ? 16'h0000 : 16'h1234));
    wait_cyc(base + 1);
    load_a = 1'b0;
    // Mid-slot reload on digit 2 (edge 42)
    for (int m = 33; m <= 48; m++) push_a(base + m, 4, exp_a(m, (m <= 42) ? 16'h1234 : 16'h5678));
    wait_cyc(base + 41);
    bcd_a = 16'h5678; load_a = 1'b1;
    wait_cyc(base + 42);
    load_a = 1'b0;
    // Leading zeros: 0070 then 0000
    for (int m = 49; m <= 64; m++) push_a(base + m, 5, exp_a(m, (m <= 49) ? 16'h5678 : 16'h0070));
    wait_cyc(base + 48);
    bcd_a = 16'h0070; load_a = 1'b1;
    wait_cyc(base + 49);
    load_a = 1'b0;
    for (int m = 65; m <= 80; m++) push_a(base + m, 5, exp_a(m, (m <= 65) ? 16'h0070 : 16'h0000));
    wait_cyc(base + 64);
    bcd_a = 16'h0000; load_a = 1'b1;
    wait_cyc(base + 65);
    load_a = 1'b0;
    // Load 4321, then reset for one edge mid-slot at idx 2 (edge 90)
    for (int m = 81; m <= 89; m++) push_a(base + m, 6, exp_a(m, (m <= 81) ? 16'h0000 : 16'h4321));
    push_a(base + 90, 6, {7'h7F, 4'b0000, 1'b0});
    wait_cyc(base + 80);
    bcd_a = 16'h4321; load_a = 1'b1;
    wait_cyc(base + 81);
    load_a = 1'b0;
    wait_cyc(base + 89);
    rst_a = 1'b1;
    wait_cyc(base + 90);
    rst_a = 1'b0;
    base = base + 90;
    for (int m = 1; m <= 20; m++) push_a(base + m, 6, exp_a(m, 16'h0000));
    wait_cyc(base + 20);
  endtask

  task automatic run_b();
    int bb;
    rst_b = 1'b1; load_b = 1'b0; bcd_b = 4'h0;
    for (int c = 1; c <= 3; c++) push_b(c, 1, {7'h00, 3'b000, 1'b1, 1'b0});
    wait_cyc(3);
    rst_b = 1'b0;
    bb = 3;
    // load held high: code captured at edge m appears after edge m+1
    for (int m = 1; m <= 20; m++) begin
      int code;
      code = (m <= 2) ? 0 : ((m - 2 > 15) ? 15 : m - 2);
      push_b(bb + m, 2, exp_b(m, code));
    end
    load_b = 1'b1;
    for (int m = 1; m <= 16; m++) begin
      wait_cyc(bb + m - 1);
      bcd_b = 4'(m - 1);
    end
    wait_cyc(bb + 17);
    load_b = 1'b0;
    bcd_b = 4'h3;
    wait_cyc(bb + 20);
  endtask

  // Monitor: compare each queued expectation at the edge it is tagged with
  always @(negedge clk) begin
    ent_t e;
    logic [11:0] act;
    while (qa.size() > 0 && (qa[0].cyc < cyc || finishing)) begin
      e = qa.pop_front();
      n_checks++; n_fails++;
      $display("FAIL dutA_missed test=%0d cyc=%0d actual=none required=%h", e.tst, e.cyc, e.val);
    end
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      act = {seg_a, dig_a, frame_a};
      n_checks++;
      if (act !== e.val) begin
        n_fails++;
        $display("FAIL dutA_out test=%0d cyc=%0d actual=%h required=%h", e.tst, e.cyc, act, e.val);
      end
    end
    while (qb.size() > 0 && (qb[0].cyc < cyc || finishing)) begin
      e = qb.pop_front();
      n_checks++; n_fails++;
      $display("FAIL dutB_missed test=%0d cyc=%0d actual=none required=%h", e.tst, e.cyc, e.val);
    end
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      act = {seg_b, 3'b000, dig_b, frame_b};
      n_checks++;
      if (act !== e.val) begin
        n_fails++;
        $display("FAIL dutB_out test=%0d cyc=%0d actual=%h required=%h", e.tst, e.cyc, act, e.val);
      end
    end
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    repeat (2) @(negedge clk);
    finishing = 1'b1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
